// File: rtl/ncl_pkg.sv
// Shared NCL definitions: rail encodings and the TH22 hysteresis rule used by NCL blocks.
package ncl_pkg;

    localparam logic NCL_NULL = 1'b0;
    localparam logic NCL_DATA = 1'b1;

    // C-element: outputs switch only when both inputs agree, otherwise hold.
    function automatic logic th22_next(input logic a, input logic b, input logic z);
        if (a && b) begin
            return NCL_DATA;
        end else if (!a && !b) begin
            return NCL_NULL;
        end
        return z;
    endfunction

endpackage

// File: rtl/ncl_th22_cell.sv
// Single-lane registered TH22 (C-element) with synchronous init to NULL.
module ncl_th22_cell
    import ncl_pkg::*;
(
    input  logic clk,
    input  logic init,
    input  logic a,
    input  logic b,
    output logic z
);

    always_ff @(posedge clk) begin
        if (init) begin
            z <= NCL_NULL;
        end else begin
            z <= th22_next(a, b, z);
        end
    end

endmodule

// File: rtl/ncl_threshold_gate_bank.sv
// Bank of registered TH12, TH22 and THnotN gates, WIDTH lanes each, with TH22 completion flags.
// Optional NCL_DUALRAIL_CHECK_EN adds a sticky dr_err flag over TH22 dual-rail pairs.
module ncl_threshold_gate_bank
    import ncl_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] th12_a,
    input  logic [WIDTH-1:0] th12_b,
    output logic [WIDTH-1:0] th12_z,
    input  logic [WIDTH-1:0] th22_a,
    input  logic [WIDTH-1:0] th22_b,
    output logic [WIDTH-1:0] th22_z,
    input  logic [WIDTH-1:0] thn_a,
    output logic [WIDTH-1:0] thn_z,
    output logic             th22_all_data,
    output logic             th22_all_null
`ifdef NCL_DUALRAIL_CHECK_EN
    ,
    output logic             dr_err
`endif
);

    always_ff @(posedge clk) begin
        if (init) begin
            th12_z <= {WIDTH{NCL_NULL}};
            thn_z  <= {WIDTH{NCL_NULL}};
        end else begin
            th12_z <= th12_a | th12_b;
            thn_z  <= ~thn_a;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_th22
        ncl_th22_cell u_cell (
            .clk  (clk),
            .init (init),
            .a    (th22_a[i]),
            .b    (th22_b[i]),
            .z    (th22_z[i])
        );
    end

    assign th22_all_data = &th22_z;
    assign th22_all_null = ~|th22_z;

`ifdef NCL_DUALRAIL_CHECK_EN
    if ((WIDTH % 2) != 0) begin : g_odd_width
        $error("ncl_threshold_gate_bank: WIDTH must be even with dual-rail checking");
    end

    logic pair_both;

    // Pairs (2k, 2k+1) are inspected on the registered values before this edge updates them.
    always_comb begin
        pair_both = 1'b0;
        for (int k = 0; k < int'(WIDTH / 2); k++) begin
            pair_both = pair_both | (th22_z[2*k] & th22_z[2*k+1]);
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            dr_err <= 1'b0;
        end else if (pair_both) begin
            dr_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ncl_threshold_gate_bank.sv
// Self-checking bench: per-lane behavioural model compared every cycle plus directed literal checks.
module tb_ncl_threshold_gate_bank;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         init;
    logic [W-1:0] th12_a, th12_b, th12_z;
    logic [W-1:0] th22_a, th22_b, th22_z;
    logic [W-1:0] thn_a, thn_z;
    logic         th22_all_data, th22_all_null;
    logic         dr_err_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ncl_threshold_gate_bank #(.WIDTH(W)) dut (
        .clk           (clk),
        .init          (init),
        .th12_a        (th12_a),
        .th12_b        (th12_b),
        .th12_z        (th12_z),
        .th22_a        (th22_a),
        .th22_b        (th22_b),
        .th22_z        (th22_z),
        .thn_a         (thn_a),
        .thn_z         (thn_z),
        .th22_all_data (th22_all_data),
        .th22_all_null (th22_all_null)
`ifdef NCL_DUALRAIL_CHECK_EN
        ,
        .dr_err        (dr_err_w)
`endif
    );

`ifndef NCL_DUALRAIL_CHECK_EN
    assign dr_err_w = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-lane arithmetic on the sampled inputs.
    logic         m_valid = 1'b0;
    logic [W-1:0] m_th12, m_th22, m_thn;
    logic         m_dr;

    function automatic logic [W-1:0] model_th22(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] z);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            int ones = int'(a[i]) + int'(b[i]);
            r[i] = (ones == 2) ? 1'b1 : (ones == 0) ? 1'b0 : z[i];
        end
        return r;
    endfunction

    function automatic logic model_pair_err(input logic [W-1:0] z);
        logic e = 1'b0;
        for (int k = 0; k < W / 2; k++) begin
            if (z[2*k] && z[2*k+1]) e = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        if (init) begin
            m_th12  <= '0;
            m_th22  <= '0;
            m_thn   <= '0;
            m_dr    <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_th12 <= th12_a | th12_b;
            m_th22 <= model_th22(th22_a, th22_b, m_th22);
            m_thn  <= ~thn_a;
            m_dr   <= m_dr | model_pair_err(m_th22);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model th12_z", 32'(th12_z), 32'(m_th12));
            check("model th22_z", 32'(th22_z), 32'(m_th22));
            check("model thn_z", 32'(thn_z), 32'(m_thn));
            check("model all_data", 32'(th22_all_data), 32'($countones(m_th22) == W));
            check("model all_null", 32'(th22_all_null), 32'($countones(m_th22) == 0));
`ifdef NCL_DUALRAIL_CHECK_EN
            check("model dr_err", 32'(dr_err_w), 32'(m_dr));
`endif
        end
    end

    // Advance one rising edge; inputs are driven and outputs read at the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    logic [1:0] ab_seq [4];
    logic       th12_exp [4];

    initial begin
        init   = 1'b1;
        th12_a = '1; th12_b = '1;
        th22_a = '1; th22_b = '1;
        thn_a  = '1;
        cyc(); cyc();
        check("reset th12_z", 32'(th12_z), 32'h0);
        check("reset th22_z", 32'(th22_z), 32'h0);
        check("reset thn_z", 32'(thn_z), 32'h0);
        check("reset all_null", 32'(th22_all_null), 32'h1);
        check("reset all_data", 32'(th22_all_data), 32'h0);
`ifdef NCL_DUALRAIL_CHECK_EN
        check("reset dr_err", 32'(dr_err_w), 32'h0);
`endif

        init = 1'b0;
        cyc();
        check("first th12_z", 32'(th12_z), 32'h3);
        check("first th22_z", 32'(th22_z), 32'h3);
        check("first thn_z", 32'(thn_z), 32'h0);
        check("first all_data", 32'(th22_all_data), 32'h1);

        // TH22 hysteresis on lane 0; lane 1 held at DATA.
        th22_a = 2'b11; th22_b = 2'b11; cyc();
        check("hyst 11", 32'(th22_z[0]), 32'h1);
        th22_a = 2'b10; th22_b = 2'b11; cyc();
        check("hyst 01 hold", 32'(th22_z[0]), 32'h1);
        th22_a = 2'b10; th22_b = 2'b10; cyc();
        check("hyst 00", 32'(th22_z[0]), 32'h0);
        check("hyst lane1", 32'(th22_z[1]), 32'h1);
        th22_a = 2'b11; th22_b = 2'b10; cyc();
        check("hyst 10 hold", 32'(th22_z[0]), 32'h0);

        // TH12 lane 1 truth table.
        ab_seq   = '{2'b00, 2'b01, 2'b10, 2'b11};
        th12_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
        th12_a = 2'b00; th12_b = 2'b00;
        for (int i = 0; i < 4; i++) begin
            th12_a[1] = ab_seq[i][1];
            th12_b[1] = ab_seq[i][0];
            cyc();
            check("th12 lane1", 32'(th12_z[1]), 32'(th12_exp[i]));
        end

        // Mid-operation reset clears held TH22 state.
        th22_a = 2'b11; th22_b = 2'b11; cyc();
        th22_a = 2'b10; th22_b = 2'b01; cyc();
        check("mixed hold", 32'(th22_z), 32'h3);
        init = 1'b1; cyc();
        check("midreset th22", 32'(th22_z), 32'h0);
        check("midreset all_null", 32'(th22_all_null), 32'h1);
        init = 1'b0; cyc();
        check("post reset mixed", 32'(th22_z), 32'h0);
        cyc();
        check("post reset mixed 2", 32'(th22_z), 32'h0);

        // THnotN acknowledge loop on lane 0.
        for (int i = 0; i < 6; i++) begin
            thn_a[0] = thn_z[0];
            cyc();
            check("thn loop", 32'(thn_z[0]), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        thn_a[0] = thn_z[0];
        init = 1'b1; cyc();
        check("thn init", 32'(thn_z), 32'h0);
        init = 1'b0;

`ifdef NCL_DUALRAIL_CHECK_EN
        th22_a = 2'b11; th22_b = 2'b11; cyc();
        check("dr pair 11", 32'(th22_z), 32'h3);
        check("dr not yet", 32'(dr_err_w), 32'h0);
        th22_a = 2'b00; th22_b = 2'b00; cyc();
        check("dr set", 32'(dr_err_w), 32'h1);
        cyc();
        check("dr sticky", 32'(dr_err_w), 32'h1);
        init = 1'b1; cyc();
        check("dr cleared", 32'(dr_err_w), 32'h0);
        init = 1'b0;
`endif
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
